prefix_decoder: RTL and testbench
=================================

# prefix_decoder

Front-end sequencer between the prefetch FIFO and the microcode sequencer. Consumes instruction bytes one per cycle, absorbs 8086 prefix bytes (segment override, LOCK, REP/REPNE), then presents the opcode byte with the accumulated prefix state. Holds that state for the whole instruction, which drives the segment override selection logic, and clears it on the microcode's next-instruction strobe or a flush.

## Interface
- MAX_PREFIXES, 4: prefix count at which `prefix_overflow` asserts; count saturates at 15 regardless.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low (asserted when 0); clears all state
- fifo_rd_data  in  8  head byte of prefetch FIFO (show-ahead, valid when `fifo_empty`=0)
- fifo_empty  in  1  FIFO has no byte
- fifo_rd_en  out  1  pop head byte this cycle (combinational)
- flush  in  1  discard partial/held instruction (branch taken)
- opcode_ready  in  1  microcode accepts presented opcode
- next_instruction  in  1  microcode finished current instruction
- opcode_valid  out  1  `opcode` and prefix outputs valid
- opcode  out  8  opcode byte following the prefixes
- seg_override  out  1  a segment prefix was seen
- seg_sel  out  2  ES=0, CS=1, SS=2, DS=3 (last segment prefix wins)
- lock  out  1  LOCK (F0) seen
- rep  out  2  00 none, 10 REPNE (F2), 11 REP/REPE (F3); last wins
- prefix_len  out  4  prefix bytes consumed, saturating at 15
- prefix_overflow  out  1  `prefix_len` >= MAX_PREFIXES

## Operation
- Prefix bytes: 26/2E/36/3E set `seg_override`=1, `seg_sel`=byte[4:3]; F0 sets `lock`; F2/F3 set `rep`. Any other byte is an opcode.
- State FETCH: `fifo_rd_en` = !`fifo_empty` && !`flush`.
  - A popped prefix updates prefix registers, increments `prefix_len`, and the FSM stays in FETCH.
  - A popped opcode latches into `opcode` and the FSM moves to PRESENT.
- State PRESENT: `opcode_valid`=1, `fifo_rd_en`=0. `opcode_ready`=1 moves to EXECUTE.
- State EXECUTE: `opcode_valid`=0, `fifo_rd_en`=0. All prefix outputs and `opcode` are held. `next_instruction`=1 clears prefix state and `prefix_len` and moves to FETCH.
- `next_instruction` is ignored in FETCH and PRESENT. `opcode_ready` is ignored outside PRESENT.
- `flush` has highest priority in every state:
  - clears prefix registers, `prefix_len`, and `opcode_valid`
  - moves to FETCH
  - no pop in that cycle
- Prefix outputs are visible while still in FETCH, reflecting the prefixes accumulated so far. Consumers qualify them with `opcode_valid` or the EXECUTE phase.
- Duplicate or conflicting prefixes are accepted without error; only the last of each class is kept. LOCK is sticky.
- `prefix_len` increments saturate at 15; further prefixes are still decoded.

## Timing
- Reset (`reset`=0), asynchronous:
  - FSM goes to FETCH.
  - `opcode`=00, `seg_override`=0, `seg_sel`=0, `lock`=0, `rep`=00, `prefix_len`=0, `prefix_overflow`=0, `opcode_valid`=0.
  - `fifo_rd_en`=0 while in reset.
  - Deassertion mid-instruction restarts cleanly in FETCH.
- Throughput: at most one byte popped per cycle.
- Latency: an opcode popped in cycle N gives `opcode_valid`=1 in cycle N+1. The fastest un-prefixed instruction issue is 1 pop + 1 present cycle.
- k prefixes then opcode, FIFO never empty: `opcode_valid` rises at cycle k+1 after the first pop.
- Empty FIFO mid-prefix stalls in FETCH; prefix state is retained.
- `opcode_ready` in the first PRESENT cycle moves to EXECUTE the next cycle. The earliest next pop is the cycle after `next_instruction`.
- `flush` and `next_instruction` in the same cycle: flush behaviour.
- `flush` and `opcode_ready` in the same cycle: flush wins, no move to EXECUTE.
- `prefix_overflow` is registered and updates with `prefix_len`.

## Test plan
- Reset mid-PRESENT with `opcode`=8B and `seg_sel`=2 → all outputs are reset values the same cycle and FSM is in FETCH; after release, byte 90 → `opcode_valid` next cycle with `seg_override`=0.
- Bytes 26, F3, A4 back-to-back, `opcode_ready`=1 → `opcode`=A4, `seg_override`=1, `seg_sel`=0, `rep`=11, `prefix_len`=2, valid on the 4th cycle; held until `next_instruction`, then all cleared.
- Bytes 2E, 3E, F2, F3, F0, 8A with MAX_PREFIXES=4 → `seg_sel`=3, `rep`=11, `lock`=1, `prefix_len`=5, `prefix_overflow`=1.
- Byte 36, FIFO empty 3 cycles, then 8B → `fifo_rd_en` is 0 while empty, `seg_sel`=2 retained, `opcode`=8B, `prefix_len`=1.
- In PRESENT, `opcode_ready` held 0 for 2 cycles, `next_instruction` pulsed → no state change, no pop; `opcode_ready`=1 → EXECUTE.
- `flush` during FETCH after prefix 26, and separately together with `next_instruction` in EXECUTE → prefixes cleared, no pop that cycle, FETCH next cycle.

Source files
------------

// File: rtl/prefix_decoder.sv
// ============================================================================
// Module      : prefix_decoder
// Description : Instruction front-end sequencer. Pops bytes from the show-ahead
//               prefetch FIFO one per cycle, absorbs 8086 prefix bytes
//               (segment override, LOCK, REP/REPNE) and presents the opcode
//               byte together with the accumulated prefix state. The prefix
//               state is held for the whole instruction and cleared when the
//               microcode signals the next instruction or a flush occurs.
//
// Ports       : clk              in   system clock, rising edge
//               reset            in   asynchronous reset, active low
//               fifo_rd_data     in   [7:0] head byte of prefetch FIFO
//               fifo_empty       in   FIFO holds no byte
//               fifo_rd_en       out  pop head byte this cycle (combinational)
//               flush            in   discard partial / held instruction
//               opcode_ready     in   microcode accepts presented opcode
//               next_instruction in   microcode finished current instruction
//               opcode_valid     out  opcode and prefix outputs valid
//               opcode           out  [7:0] opcode byte after the prefixes
//               seg_override     out  a segment prefix was seen
//               seg_sel          out  [1:0] ES=0 CS=1 SS=2 DS=3, last wins
//               lock             out  LOCK (F0) seen
//               rep              out  [1:0] 00 none, 10 REPNE, 11 REP/REPE
//               prefix_len       out  [3:0] prefix bytes consumed, sat. at 15
//               prefix_overflow  out  prefix_len >= MAX_PREFIXES
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prefix_decoder #(
    parameter int MAX_PREFIXES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] fifo_rd_data,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    input  logic       flush,
    input  logic       opcode_ready,
    input  logic       next_instruction,
    output logic       opcode_valid,
    output logic [7:0] opcode,
    output logic       seg_override,
    output logic [1:0] seg_sel,
    output logic       lock,
    output logic [1:0] rep,
    output logic [3:0] prefix_len,
    output logic       prefix_overflow
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_FETCH   = 2'd0;
    localparam logic [1:0] c_PRESENT = 2'd1;
    localparam logic [1:0] c_EXECUTE = 2'd2;

    localparam logic [3:0] c_LEN_MAX = 4'hF;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0] r_state;
    logic [7:0] r_opcode;
    logic       r_seg_override;
    logic [1:0] r_seg_sel;
    logic       r_lock;
    logic [1:0] r_rep;
    logic [3:0] r_prefix_len;
    logic       r_prefix_overflow;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic       w_is_seg;
    logic       w_is_lock;
    logic       w_is_rep;
    logic       w_is_prefix;
    logic       w_pop;
    logic       w_clear;
    logic [1:0] w_state_next;
    logic [3:0] w_len_inc;
    logic       w_ovf_inc;

    // ------------------------------------------------------------------------
    // Prefix byte classification
    //   26/2E/36/3E = 001x_x110 : segment override, selector in bits [4:3]
    //   F0                      : LOCK
    //   F2/F3       = 1111_001x : REPNE / REP, bit 0 distinguishes them
    // ------------------------------------------------------------------------
    always_comb begin
        w_is_seg    = (fifo_rd_data[7:5] == 3'b001) && (fifo_rd_data[2:0] == 3'b110);
        w_is_lock   = (fifo_rd_data == 8'hF0);
        w_is_rep    = (fifo_rd_data[7:1] == 7'b1111_001);
        w_is_prefix = w_is_seg || w_is_lock || w_is_rep;
    end

    // A pop only ever happens in FETCH; flush suppresses it in that cycle.
    assign w_pop = (r_state == c_FETCH) && !fifo_empty && !flush;

    // Gate with reset so the FIFO is never popped while reset is asserted,
    // even though the state register already sits in FETCH.
    assign fifo_rd_en = w_pop && reset;

    // Saturating prefix counter and its overflow flag, computed for the
    // value the counter is about to take.
    always_comb begin
        w_len_inc = (r_prefix_len == c_LEN_MAX) ? c_LEN_MAX : (r_prefix_len + 4'd1);
        w_ovf_inc = ({28'd0, w_len_inc} >= MAX_PREFIXES);
    end

    // ------------------------------------------------------------------------
    // Next-state logic. Flush overrides everything, including a simultaneous
    // opcode_ready or next_instruction.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;

        if (flush) begin
            w_state_next = c_FETCH;
            w_clear      = 1'b1;
        end else begin
            case (r_state)
                c_FETCH: begin
                    if (w_pop && !w_is_prefix) begin
                        w_state_next = c_PRESENT;
                    end
                end
                c_PRESENT: begin
                    if (opcode_ready) begin
                        w_state_next = c_EXECUTE;
                    end
                end
                c_EXECUTE: begin
                    if (next_instruction) begin
                        w_state_next = c_FETCH;
                        w_clear      = 1'b1;
                    end
                end
                default: begin
                    // Unused encoding: recover into a clean fetch.
                    w_state_next = c_FETCH;
                    w_clear      = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Opcode register. Only written when an opcode byte is popped; it is not
    // cleared between instructions since opcode_valid qualifies it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_opcode <= 8'h00;
        end else if (w_pop && !w_is_prefix) begin
            r_opcode <= fifo_rd_data;
        end
    end

    // ------------------------------------------------------------------------
    // Prefix state. Within each class the last prefix wins; LOCK is sticky.
    // Prefixes past the counter saturation point are still decoded.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seg_override    <= 1'b0;
            r_seg_sel         <= 2'd0;
            r_lock            <= 1'b0;
            r_rep             <= 2'b00;
            r_prefix_len      <= 4'd0;
            r_prefix_overflow <= 1'b0;
        end else if (w_clear) begin
            r_seg_override    <= 1'b0;
            r_seg_sel         <= 2'd0;
            r_lock            <= 1'b0;
            r_rep             <= 2'b00;
            r_prefix_len      <= 4'd0;
            r_prefix_overflow <= 1'b0;
        end else if (w_pop && w_is_prefix) begin
            if (w_is_seg) begin
                r_seg_override <= 1'b1;
                r_seg_sel      <= fifo_rd_data[4:3];
            end
            if (w_is_lock) begin
                r_lock <= 1'b1;
            end
            if (w_is_rep) begin
                r_rep <= {1'b1, fifo_rd_data[0]};
            end
            r_prefix_len      <= w_len_inc;
            r_prefix_overflow <= w_ovf_inc;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign opcode_valid    = (r_state == c_PRESENT);
    assign opcode          = r_opcode;
    assign seg_override    = r_seg_override;
    assign seg_sel         = r_seg_sel;
    assign lock            = r_lock;
    assign rep             = r_rep;
    assign prefix_len      = r_prefix_len;
    assign prefix_overflow = r_prefix_overflow;

endmodule

`default_nettype wire

// File: tb/tb_prefix_decoder.sv
// ============================================================================
// Module      : tb_prefix_decoder
// Description : Self-checking bench for prefix_decoder. Stimulus drives the
//               FIFO / microcode handshake, a behavioural model keeps the list
//               of consumed prefix bytes and derives the expected prefix state
//               by scanning it; completed instructions go into a scoreboard
//               queue that a separate monitor drains on opcode_valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prefix_decoder;

    localparam int MAX_PREFIXES = 4;

    typedef struct packed {
        logic [7:0] op;
        logic       so;
        logic [1:0] ss;
        logic       lk;
        logic [1:0] rp;
        logic [3:0] len;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       fifo_empty = 1'b1;
    logic       fifo_rd_en;
    logic       flush = 1'b0;
    logic       opcode_ready = 1'b0;
    logic       next_instruction = 1'b0;
    logic       opcode_valid;
    logic [7:0] opcode;
    logic       seg_override;
    logic [1:0] seg_sel;
    logic       lock;
    logic [1:0] rep;
    logic [3:0] prefix_len;
    logic       prefix_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0 = collecting bytes, 1 = opcode offered, 2 = executing.
    int         m_phase = 0;
    logic [7:0] m_pfx[$];
    exp_t       sb_q[$];

    prefix_decoder #(.MAX_PREFIXES(MAX_PREFIXES)) dut (
        .clk              (clk),
        .reset            (reset),
        .fifo_rd_data     (fifo_rd_data),
        .fifo_empty       (fifo_empty),
        .fifo_rd_en       (fifo_rd_en),
        .flush            (flush),
        .opcode_ready     (opcode_ready),
        .next_instruction (next_instruction),
        .opcode_valid     (opcode_valid),
        .opcode           (opcode),
        .seg_override     (seg_override),
        .seg_sel          (seg_sel),
        .lock             (lock),
        .rep              (rep),
        .prefix_len       (prefix_len),
        .prefix_overflow  (prefix_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_prefix(input logic [7:0] b);
        return (b == 8'h26) || (b == 8'h2E) || (b == 8'h36) || (b == 8'h3E) ||
               (b == 8'hF0) || (b == 8'hF2) || (b == 8'hF3);
    endfunction

    // Expected prefix state from the list of prefixes consumed so far.
    function automatic exp_t make_exp(input logic [7:0] op);
        exp_t e;
        int   n;
        e    = '0;
        e.op = op;
        foreach (m_pfx[i]) begin
            case (m_pfx[i])
                8'h26: begin e.so = 1'b1; e.ss = 2'd0; end
                8'h2E: begin e.so = 1'b1; e.ss = 2'd1; end
                8'h36: begin e.so = 1'b1; e.ss = 2'd2; end
                8'h3E: begin e.so = 1'b1; e.ss = 2'd3; end
                8'hF0: e.lk = 1'b1;
                8'hF2: e.rp = 2'b10;
                8'hF3: e.rp = 2'b11;
                default: ;
            endcase
        end
        n     = (m_pfx.size() > 15) ? 15 : m_pfx.size();
        e.len = 4'(n);
        e.ovf = (n >= MAX_PREFIXES);
        return e;
    endfunction

    // One clock cycle of stimulus; entered and left just after a negedge.
    task automatic step(input bit have, input logic [7:0] data, input bit fl,
                        input bit rdy, input bit nxt);
        bit   exp_pop;
        exp_t e;
        fifo_empty       = !have;
        fifo_rd_data     = data;
        flush            = fl;
        opcode_ready     = rdy;
        next_instruction = nxt;
        #1;
        exp_pop = (m_phase == 0) && have && !fl;
        e       = make_exp(8'h00);
        chk("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_pop));
        chk("opcode_valid", 32'(opcode_valid), 32'(m_phase == 1));
        chk("prefix_state", {20'd0, seg_override, seg_sel, lock, rep, prefix_len, prefix_overflow},
            {20'd0, e.so, e.ss, e.lk, e.rp, e.len, e.ovf});
        @(posedge clk);
        if (fl) begin
            m_phase = 0;
            m_pfx.delete();
        end else begin
            case (m_phase)
                0: if (exp_pop) begin
                    if (is_prefix(data)) begin
                        m_pfx.push_back(data);
                    end else begin
                        sb_q.push_back(make_exp(data));
                        m_phase = 1;
                    end
                end
                1: if (rdy) m_phase = 2;
                default: if (nxt) begin
                    m_phase = 0;
                    m_pfx.delete();
                end
            endcase
        end
        @(negedge clk);
    endtask

    // Scoreboard monitor: compares each newly presented instruction, and
    // checks the held outputs on every further cycle of the same instruction.
    initial begin : monitor
        logic prev_valid;
        exp_t cur;
        prev_valid = 1'b0;
        cur        = '0;
        forever begin
            @(negedge clk);
            #2;
            if (opcode_valid && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_opcode_valid", 32'd1, 32'd0);
                end else begin
                    cur = sb_q.pop_front();
                    chk("presented_instr",
                        {13'd0, opcode, seg_override, seg_sel, lock, rep, prefix_len, prefix_overflow},
                        {13'd0, cur});
                end
            end else if (opcode_valid) begin
                chk("held_opcode", 32'(opcode), 32'(cur.op));
            end
            prev_valid = opcode_valid;
        end
    end

    initial begin : stimulus
        logic [7:0] pfx_tab[7];
        logic [7:0] b;
        pfx_tab = '{8'h26, 8'h2E, 8'h36, 8'h3E, 8'hF0, 8'hF2, 8'hF3};

        // Reset values while reset held, FIFO non-empty.
        fifo_empty = 1'b0;
        fifo_rd_data = 8'h90;
        repeat (2) @(negedge clk);
        chk("reset_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("reset_outputs", {13'd0, opcode_valid, opcode, seg_override, seg_sel, lock, rep, prefix_len, prefix_overflow}, 32'd0);
        reset = 1'b1;

        // Reset mid-PRESENT with opcode 8B and seg_sel 2.
        step(1, 8'h36, 0, 0, 0);
        step(1, 8'h8B, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset_outputs", {13'd0, opcode_valid, opcode, seg_override, seg_sel, lock, rep, prefix_len, prefix_overflow}, 32'd0);
        chk("async_reset_rd_en", 32'(fifo_rd_en), 32'd0);
        m_phase = 0;
        m_pfx.delete();
        @(negedge clk);
        reset = 1'b1;
        step(1, 8'h90, 0, 0, 0);
        step(0, 8'h00, 0, 1, 0);
        step(0, 8'h00, 0, 0, 1);

        // 26 F3 A4 back-to-back, held through execute, then cleared.
        step(1, 8'h26, 0, 1, 0);
        step(1, 8'hF3, 0, 1, 0);
        step(1, 8'hA4, 0, 1, 0);
        step(1, 8'h11, 0, 1, 0);
        step(1, 8'h11, 0, 0, 0);
        step(1, 8'h11, 0, 0, 0);
        step(1, 8'h11, 0, 0, 1);

        // Five prefixes then opcode: overflow.
        step(1, 8'h2E, 0, 0, 0);
        step(1, 8'h3E, 0, 0, 0);
        step(1, 8'hF2, 0, 0, 0);
        step(1, 8'hF3, 0, 0, 0);
        step(1, 8'hF0, 0, 0, 0);
        step(1, 8'h8A, 0, 0, 0);
        // PRESENT: ready low, next_instruction pulsed - no change.
        step(1, 8'h22, 0, 0, 0);
        step(1, 8'h22, 0, 0, 1);
        step(1, 8'h22, 0, 1, 0);
        step(1, 8'h22, 0, 0, 1);

        // Prefix, empty FIFO stall, then opcode.
        step(1, 8'h36, 0, 0, 0);
        repeat (3) step(0, 8'h36, 0, 0, 0);
        step(1, 8'h8B, 0, 0, 0);
        step(0, 8'h00, 0, 1, 0);
        step(0, 8'h00, 0, 0, 1);

        // Flush during FETCH after prefix 26.
        step(1, 8'h26, 0, 0, 0);
        step(1, 8'h90, 1, 0, 0);
        step(1, 8'h90, 0, 1, 0);
        // Flush together with next_instruction in EXECUTE.
        step(1, 8'hF0, 0, 1, 0);
        step(1, 8'h01, 0, 1, 0);
        step(1, 8'h01, 0, 1, 0);
        step(1, 8'h01, 1, 0, 1);
        // Flush together with opcode_ready in PRESENT.
        step(1, 8'h02, 0, 0, 0);
        step(1, 8'h02, 1, 1, 0);

        // Long prefix run: counter saturation at 15.
        for (int i = 0; i < 18; i++) step(1, pfx_tab[i % 7], 0, 0, 0);
        step(1, 8'hC3, 0, 0, 0);
        step(0, 8'h00, 0, 1, 0);
        step(0, 8'h00, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                b = pfx_tab[$urandom_range(0, 6)];
            end else begin
                b = 8'($urandom);
                if (is_prefix(b)) b = 8'h90;
            end
            step($urandom_range(0, 3) != 0, b, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
        end

        step(0, 8'h00, 1, 0, 0);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
